// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (5..9 data bits, none/even/odd
// parity, 1 or 2 stop bits) with a valid/ready input handshake and
// busy/done status. All outputs are registered; txd idles high.
module uart_tx_frame #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BPS_CNT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int BIT_W   = $clog2(DATA_BITS + 1);

  // Reject parameter combinations the frame logic cannot honour.
  generate
    if (BPS_CNT < 2) begin : g_bad_baud
      $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 txd_q, txd_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == CNT_W'(BPS_CNT - 1));

  // Next-state logic: every output is computed for the cycle after the edge,
  // so txd/ready/busy/done come straight out of flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        txd_d   = 1'b1;
        if (tx_valid && ready_q) begin
          shift_d  = tx_data;
          parity_d = (PARITY_MODE == 2) ? ~(^tx_data) : ^tx_data;
          state_d  = START;
          cnt_d    = '0;
          txd_d    = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d     = '0;
          state_d   = DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            if (PARITY_MODE != 0) begin
              state_d = PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d      = '0;
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b1;
        end
      end
      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        txd_d = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the line high and drops any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmitter; next generation of the team's fixed 8N1 serial transmitter.
- Adds configurable data width (5–9 bits), optional even/odd parity and 1 or 2 stop bits.
- Replaces edge-triggered enable with a synchronous valid/ready handshake, plus busy and done status.
- Sits between a byte-stream source (FIFO or command engine) and the board TXD pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s. BPS_CNT = CLK_FREQ / BAUD_RATE (integer divide); must be >= 2.
- DATA_BITS, 8, payload bits per frame; legal values 5..9.
- PARITY_MODE, 0, parity bit: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  source has a word on tx_data; synchronous to clk.
- tx_data  input  DATA_BITS  word to transmit, sent LSB first.
- tx_ready  output  1  block can accept a word this cycle.
- txd  output  1  serial line; idles high; registered output.
- tx_busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - Reset values: txd=1, tx_ready=0, tx_busy=0, tx_done=0, state=IDLE, counters=0.
  - tx_ready rises on the first clk edge after rst_n deasserts.
- Reset mid-frame: txd returns high immediately (asynchronous) and the frame is abandoned. No tx_done is generated.
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - PARITY is skipped when PARITY_MODE=0.
- Handshake:
  - Accept occurs on a clk edge where tx_valid && tx_ready.
  - tx_ready = 1 only in IDLE.
  - tx_data is captured into a shift register at accept; later changes to tx_data are ignored.
  - tx_valid while not ready has no effect. The source holds tx_valid and tx_data until accepted.
- Latency: txd drives 0 (start bit) on the cycle after the accept edge.
- Bit timing:
  - Clock counter runs 0..BPS_CNT-1; every bit (start, data, parity, stop) lasts exactly BPS_CNT cycles.
  - Counter width is $clog2(BPS_CNT).
- Data: bits are sent LSB first. A bit counter (width $clog2(DATA_BITS+1)) advances at each counter wrap. DATA exits after DATA_BITS bits.
- Parity:
  - Computed at accept from the captured word.
  - Even: txd = XOR of data bits.
  - Odd: txd = inverted XOR of data bits.
- Stop: txd = 1 for STOP_BITS*BPS_CNT cycles.
- Completion:
  - On the last cycle of the last stop bit, the state moves to IDLE.
  - tx_done pulses for exactly one cycle, coincident with the first IDLE cycle; tx_ready is also 1 in that cycle.
- Frame length: (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * BPS_CNT cycles, measured from the start-bit cycle to the last stop cycle.
- Back-to-back: with tx_valid held high, the next accept happens in the tx_done cycle. The line stays high for exactly one extra clk cycle between frames.
- Illegal parameter values: a generate-time $error is raised.

Test Plan:
- Sim clock: CLK_FREQ=1000000, BAUD_RATE=100000, so BPS_CNT=10.
- 8N1: send 0xA5 -> txd low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles.
  - tx_done pulses at cycle 101 after accept; tx_busy is high for cycles 1..100.
- 8E2 (PARITY_MODE=1, STOP_BITS=2): 0x07 -> parity bit 1; 0x03 -> parity bit 0. Frame length 120 cycles.
- 7O1 (DATA_BITS=7, PARITY_MODE=2): 0x00 -> parity bit 1; 0x7F -> parity bit 0. Frame length 100 cycles.
- Handshake:
  - tx_valid held high with three words -> exactly three frames, one-cycle idle gap between each.
  - tx_data changed mid-frame -> transmitted word unchanged.
  - tx_ready is low throughout busy.
- Reset: assert rst_n at cycle 45 of a frame -> txd=1 with no clk edge, no tx_done.
  - After release, tx_ready=1 on the next edge and a fresh 0x3C frame transmits correctly.
